// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: FSM states, the presented-slot record, NOP and cause codes.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP             = 32'h0000_0013;
  localparam logic [3:0]  CAUSE_IMISALIGN = 4'd0;
  localparam logic [3:0]  CAUSE_IFAULT    = 4'd1;

  typedef struct packed {
    logic        valid;
    logic        except;
    logic [3:0]  cause;
    logic [63:0] pc;
    logic [63:0] npc;
    logic [63:0] ppc;
    logic [31:0] inst;
  } slot_t;

  // An empty slot still presents a NOP so IF/ID never latches garbage.
  function automatic slot_t empty_slot();
    slot_t s;
    s        = '0;
    s.inst   = NOP;
    return s;
  endfunction

endpackage

// File: rtl/fetch_slot_reg.sv
// One-entry output slot feeding IF/ID: clear on redirect, load on fill, hold under stall.
module fetch_slot_reg
  import fetch_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clear,
  input  logic  load,
  input  logic  stall,
  input  slot_t slot_d,
  output slot_t slot_q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_q <= empty_slot();
    end else if (clear) begin
      slot_q <= empty_slot();
    end else if (load) begin
      slot_q <= slot_d;
    end else if (!stall) begin
      // Downstream consumed the entry this edge and nothing replaced it.
      slot_q <= empty_slot();
    end
  end

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch: PC, one-outstanding imem request FSM, and the registered IF/ID slot.
module instr_fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  input  logic        bp_taken,
  input  logic [63:0] bp_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  output logic        valid_if,
  output logic [63:0] pc_if,
  output logic [63:0] npc_if,
  output logic [63:0] predict_pc_if,
  output logic [31:0] inst_if,
  output logic        except_happen_if,
  output logic [3:0]  except_cause_if
);

  fetch_state_e state_reg;
  logic [63:0]  pc_reg;
  logic [63:0]  req_pc_reg;
  logic [63:0]  req_ppc_reg;
  logic         fault_hold_reg;

  slot_t        slot_q;
  slot_t        slot_d;
  logic         slot_load;

  logic         slot_free;
  logic         pc_aligned;
  logic [63:0]  prediction;
  logic         can_issue;
  logic         handshake;
  logic         misalign_trap;
  logic         resp_in_wait;

  assign slot_free    = !(slot_q.valid || slot_q.except) || !stall;
  assign pc_aligned   = (pc_reg[1:0] == 2'b00);
  assign prediction   = bp_taken ? bp_target : pc_reg + 64'd4;
  assign resp_in_wait = (state_reg == S_WAIT) && imem_resp_valid;

  // A completing response frees the single outstanding slot, so the next request may go out alongside it.
  assign can_issue     = rst && slot_free && pc_aligned && !fault_hold_reg &&
                         ((state_reg == S_REQ) || resp_in_wait);
  assign handshake     = can_issue && imem_req_ready;
  assign misalign_trap = (state_reg == S_REQ) && slot_free && !pc_aligned && !fault_hold_reg;

  assign imem_req_valid = can_issue;
  assign imem_addr      = pc_reg;

  always_comb begin
    slot_d    = empty_slot();
    slot_load = 1'b0;
    if (resp_in_wait) begin
      slot_load = 1'b1;
      slot_d.pc  = req_pc_reg;
      slot_d.ppc = req_ppc_reg;
      if (imem_resp_err) begin
        slot_d.except = 1'b1;
        slot_d.cause  = CAUSE_IFAULT;
      end else begin
        slot_d.valid = 1'b1;
        slot_d.npc   = req_pc_reg + 64'd4;
        slot_d.inst  = imem_resp_data;
      end
    end else if (misalign_trap) begin
      slot_load     = 1'b1;
      slot_d.except = 1'b1;
      slot_d.cause  = CAUSE_IMISALIGN;
      slot_d.pc     = pc_reg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= S_REQ;
      pc_reg         <= RESET_PC;
      req_pc_reg     <= '0;
      req_ppc_reg    <= '0;
      fault_hold_reg <= 1'b0;
    end else if (redirect) begin
      pc_reg         <= redirect_pc;
      fault_hold_reg <= 1'b0;
      if (handshake) begin
        state_reg <= S_DROP;
      end else begin
        case (state_reg)
          S_WAIT, S_DROP: state_reg <= imem_resp_valid ? S_REQ : S_DROP;
          default:        state_reg <= S_REQ;
        endcase
      end
    end else begin
      if (handshake) begin
        req_pc_reg  <= pc_reg;
        req_ppc_reg <= prediction;
        pc_reg      <= prediction;
      end
      case (state_reg)
        S_REQ: begin
          if (handshake) begin
            state_reg <= S_WAIT;
          end else if (misalign_trap) begin
            fault_hold_reg <= 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid && !handshake) begin
            state_reg <= S_REQ;
          end
        end
        S_DROP: begin
          if (imem_resp_valid) begin
            state_reg <= S_REQ;
          end
        end
        default: state_reg <= S_REQ;
      endcase
    end
  end

  fetch_slot_reg u_slot (
    .clk    (clk),
    .rst    (rst),
    .clear  (redirect),
    .load   (slot_load),
    .stall  (stall),
    .slot_d (slot_d),
    .slot_q (slot_q)
  );

  assign valid_if         = slot_q.valid;
  assign pc_if            = slot_q.pc;
  assign npc_if           = slot_q.npc;
  assign predict_pc_if    = slot_q.ppc;
  assign inst_if          = slot_q.inst;
  assign except_happen_if = slot_q.except;
  assign except_cause_if  = slot_q.cause;

endmodule
